// File: rtl/run_cnt_ctrl.sv
// rtl/run_cnt_ctrl.sv - run controller that arms, starts and times one per-PE event counter
module run_cnt_ctrl #(
    parameter int CNT_W = 32,
    parameter int TO_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [CNT_W-1:0] cmd_target,
    input  logic [TO_W-1:0]  cmd_timeout,
    output logic             sys_start,
    input  logic [CNT_W-1:0] pe_cnt,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [CNT_W-1:0] rsp_cnt,
    output logic [TO_W-1:0]  rsp_cyc,
    output logic             rsp_timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_START,
        ST_RUN,
        ST_REPORT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [TO_W-1:0]  timeout_q, timeout_d;
    logic [TO_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
    logic [TO_W-1:0]  rsp_cyc_q, rsp_cyc_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic [TO_W-1:0]  cyc_inc;
    logic [TO_W-1:0]  cyc_sat;

    // cyc_inc feeds the timeout compare; cyc_sat is what gets stored and reported
    assign cyc_inc = cyc_q + 1'b1;
    assign cyc_sat = (cyc_q == '1) ? cyc_q : cyc_inc;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        timeout_d     = timeout_q;
        cyc_d         = cyc_q;
        rsp_cnt_d     = rsp_cnt_q;
        rsp_cyc_d     = rsp_cyc_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    target_d  = cmd_target;
                    timeout_d = cmd_timeout;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_START;
            end
            ST_START: begin
                cyc_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // target is tested first so a same-cycle tie reports success
                if (pe_cnt >= target_q) begin
                    rsp_cnt_d     = pe_cnt;
                    rsp_cyc_d     = cyc_sat;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_REPORT;
                end else if ((timeout_q != '0) && (cyc_inc == timeout_q)) begin
                    rsp_cnt_d     = pe_cnt;
                    rsp_cyc_d     = cyc_sat;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_REPORT;
                end else begin
                    cyc_d = cyc_sat;
                end
            end
            ST_REPORT: begin
                if (rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            timeout_q     <= '0;
            cyc_q         <= '0;
            rsp_cnt_q     <= '0;
            rsp_cyc_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            timeout_q     <= timeout_d;
            cyc_q         <= cyc_d;
            rsp_cnt_q     <= rsp_cnt_d;
            rsp_cyc_q     <= rsp_cyc_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_rdy     = (state_q == ST_IDLE);
    assign sys_start   = (state_q == ST_START) || (state_q == ST_RUN);
    assign rsp_vld     = (state_q == ST_REPORT);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_cnt     = rsp_cnt_q;
    assign rsp_cyc     = rsp_cyc_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
